// File: rtl/loader_pkg.sv
// Shared types and widths for the UART program loader and its serial receiver.
package loader_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BYTE,
        SETUP,
        WRITE,
        DONE,
        ERROR
    } loader_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronised input, mid-bit sampling, one-cycle valid / frame-error pulses.
module uart_rx
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             sync1_q, sync2_q, prev_q;

    // Synchroniser and edge-detect history preset high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            sync1_q <= rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (prev_q && !sync2_q) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = sync2_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d  = '0;
                    data_d = {sync2_q, data_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    valid_d = sync2_q;
                    err_d   = !sync2_q;
                    state_d = RX_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_data      = data_q;
        rx_valid     = valid_q;
        rx_frame_err = err_q;
    end

endmodule

// File: rtl/uart_program_loader.sv
// Streams a RAM_DEPTH-byte image from a UART into the program RAM via its manual-mode port.
module uart_program_loader
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int RAM_DEPTH    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              uart_rx,
    output logic              manual_mode,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] program_switches,
    output logic              manual_read,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(RAM_DEPTH - 1);

    loader_state_t     state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_frame_err;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx          (uart_rx),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_frame_err(rx_frame_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            IDLE, DONE, ERROR: begin
                if (load_start) begin
                    state_d = WAIT_BYTE;
                    idx_d   = '0;
                end
            end
            WAIT_BYTE: begin
                // A byte can never finish in SETUP/WRITE, so only this state watches the receiver.
                if (rx_valid) begin
                    addr_d  = idx_q;
                    data_d  = rx_data;
                    state_d = SETUP;
                end else if (rx_frame_err) begin
                    state_d = ERROR;
                end
            end
            SETUP: state_d = WRITE;
            WRITE: begin
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = WAIT_BYTE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs: manual_mode and done/error switch on the same edge that changes state.
    always_comb begin
        busy             = (state_q == WAIT_BYTE) || (state_q == SETUP) || (state_q == WRITE);
        manual_mode      = busy;
        manual_read      = (state_q == WRITE);
        done             = (state_q == DONE);
        error            = (state_q == ERROR);
        address          = addr_q;
        program_switches = data_q;
    end

endmodule

// File: tb/tb_uart_program_loader.sv
// Randomised bench: bytes are framed onto uart_rx, a loader model predicts RAM writes and flags.
module tb_uart_program_loader;

    localparam int CPB   = 4;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load_start;
    logic       uart_rx;
    logic       manual_mode;
    logic [3:0] address;
    logic [7:0] program_switches;
    logic       manual_read;
    logic       busy;
    logic       done;
    logic       error;

    always #5 clk = ~clk;

    uart_program_loader #(
        .CLKS_PER_BIT(CPB),
        .RAM_DEPTH   (DEPTH)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .load_start      (load_start),
        .uart_rx         (uart_rx),
        .manual_mode     (manual_mode),
        .address         (address),
        .program_switches(program_switches),
        .manual_read     (manual_read),
        .busy            (busy),
        .done            (done),
        .error           (error)
    );

    int          total = 0;
    int          bad   = 0;
    logic [11:0] exp_q[$];
    logic [7:0]  ram[DEPTH];
    logic [7:0]  img[DEPTH];
    int          strobes = 0;

    // Loader reference model: a load is a count of accepted bytes plus the final outcome.
    bit         m_busy = 0;
    bit         m_done = 0;
    bit         m_err  = 0;
    int         m_idx  = 0;
    logic [3:0] m_addr = '0;
    logic [7:0] m_data = '0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
        end
    endtask

    logic       prev_read = 1'b0;
    logic [3:0] prev_addr = '0;
    logic [7:0] prev_data = '0;

    // Behavioural RAM plus strobe monitor: every write is matched against the expected queue.
    always @(negedge clk) begin
        logic [11:0] e;
        if (manual_read) begin
            strobes++;
            ram[address] = program_switches;
            chk("strobe_mode", manual_mode, 1);
            chk("strobe_width", prev_read, 0);
            chk("setup_stable", {prev_addr, prev_data}, {address, program_switches});
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_strobe got=%0h want=none at %0t",
                         {address, program_switches}, $time);
            end else begin
                e = exp_q.pop_front();
                chk("write_addr_data", {address, program_switches}, e);
            end
        end
        prev_read = manual_read;
        prev_addr = address;
        prev_data = program_switches;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        logic [9:0] frame;
        if (m_busy) begin
            if (stop) begin
                exp_q.push_back({4'(m_idx), b});
                m_addr = 4'(m_idx);
                m_data = b;
                if (m_idx == DEPTH - 1) begin
                    m_busy = 0;
                    m_done = 1;
                end else begin
                    m_idx++;
                end
            end else begin
                m_busy = 0;
                m_err  = 1;
            end
        end
        frame = {stop, b, 1'b0};
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            uart_rx = frame[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        uart_rx = 1'b1;
    endtask

    task automatic glitch();
        @(posedge clk);
        #1 uart_rx = 1'b0;
        @(posedge clk);
        #1 uart_rx = 1'b1;
        repeat (2 * CPB) @(posedge clk);
        #1;
    endtask

    task automatic pulse_load();
        @(posedge clk);
        #1 load_start = 1'b1;
        if (!m_busy) begin
            m_busy = 1;
            m_done = 0;
            m_err  = 0;
            m_idx  = 0;
        end
        @(posedge clk);
        #1 load_start = 1'b0;
        chk("mode_after_load", manual_mode, m_busy);
    endtask

    task automatic settle();
        int n = 0;
        while (exp_q.size() != 0 && n < 80) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL settle_timeout got=%0d want=0 pending writes", exp_q.size());
            exp_q.delete();
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_flags(input string tag);
        chk({tag, "_mode"}, manual_mode, m_busy);
        chk({tag, "_busy"}, busy, m_busy);
        chk({tag, "_done"}, done, m_done);
        chk({tag, "_error"}, error, m_err);
        chk({tag, "_addr"}, address, m_addr);
        chk({tag, "_data"}, program_switches, m_data);
    endtask

    task automatic full_load(input bit ramp);
        int s0;
        s0 = strobes;
        pulse_load();
        for (int i = 0; i < DEPTH; i++) begin
            img[i] = ramp ? 8'(8'h10 + i) : 8'($urandom_range(0, 255));
            send_byte(img[i], 1'b1);
        end
        settle();
        chk("load_strobe_count", strobes - s0, DEPTH);
        for (int i = 0; i < DEPTH; i++) chk("ram_image", ram[i], img[i]);
        check_flags("after_load");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s0;
        logic [7:0] old3;
        uart_rx    = 1'b1;
        load_start = 1'b0;
        rst_n      = 1'b0;
        #12;
        check_flags("reset");
        chk("reset_read", manual_read, 0);
        @(negedge clk) rst_n = 1'b1;

        // Ramp image 0x10..0x1F, then one extra byte that must be discarded at the wrap.
        full_load(1'b1);
        s0 = strobes;
        send_byte(8'($urandom_range(0, 255)), 1'b1);
        settle();
        chk("wrap_no_17th", strobes - s0, 0);
        check_flags("after_wrap");

        // Single-byte write timing, a busy load_start, and a false start mid-load.
        pulse_load();
        img[0] = 8'hA5;
        send_byte(img[0], 1'b1);
        settle();
        check_flags("single_byte");
        pulse_load();
        chk("busy_load_ignored", busy, 1);
        glitch();
        for (int i = 1; i < DEPTH; i++) begin
            img[i] = 8'($urandom_range(0, 255));
            send_byte(img[i], 1'b1);
            if (i == 5) glitch();
        end
        settle();
        for (int i = 0; i < DEPTH; i++) chk("ram_image2", ram[i], img[i]);
        check_flags("after_load2");

        // Framing error after three good bytes, then traffic in ERROR, then recovery.
        old3 = ram[3];
        pulse_load();
        for (int i = 0; i < 3; i++) begin
            img[i] = 8'($urandom_range(0, 255));
            send_byte(img[i], 1'b1);
        end
        send_byte(~old3, 1'b0);
        settle();
        check_flags("frame_err");
        chk("ram3_untouched", ram[3], old3);
        for (int i = 0; i < 3; i++) chk("ram_partial", ram[i], img[i]);
        s0 = strobes;
        send_byte(8'($urandom_range(0, 255)), 1'b1);
        settle();
        chk("error_state_discard", strobes - s0, 0);
        full_load(1'b0);

        // Reset mid-load after five bytes; outputs must fall without a clock edge.
        pulse_load();
        for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
        settle();
        @(negedge clk);
        #2 rst_n = 1'b0;
        m_busy = 0;
        m_done = 0;
        m_err  = 0;
        m_idx  = 0;
        m_addr = '0;
        m_data = '0;
        #1;
        check_flags("async_reset");
        chk("async_reset_read", manual_read, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_flags("post_reset");
        s0 = strobes;
        send_byte(8'($urandom_range(0, 255)), 1'b1);
        settle();
        chk("idle_discard", strobes - s0, 0);
        full_load(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
